// File: rtl/mem_ss_rst_seq_pkg.sv
// Shared types and constants for the memory subsystem reset sequencer and
// the EMIF CSR block that reads its status/capability values.
package mem_ss_rst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_REL  = 3'd2,
        ST_CAL  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } t_seq_state;

    // Bit positions inside the emif_status word
    localparam int STS_FAIL_LSB = 8;
    localparam int STS_BUSY     = 16;
    localparam int STS_ACK_TO   = 17;
    localparam int STS_CAL_TO   = 18;
    localparam int STS_CAL_LOST = 19;

    // Byte offsets of the two registers inside the EMIF DFH feature
    localparam logic [19:0] EMIF_STATUS_OFFSET     = 20'h0_0008;
    localparam logic [19:0] EMIF_CAPABILITY_OFFSET = 20'h0_0010;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        max_u = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_ss_rst_seq_if.sv
// Reset handshake and calibration status bundle between the sequencer
// (master) and mem_ss_top (slave).
interface mem_ss_rst_seq_if #(
    parameter int NUM_MEM_CH = 4
);
    logic                  mem_ss_rst_req_n;
    logic                  mem_ss_rst_ack_n;
    logic [NUM_MEM_CH-1:0] mem_ss_cal_success;
    logic [NUM_MEM_CH-1:0] mem_ss_cal_fail;

    modport master (
        output mem_ss_rst_req_n,
        input  mem_ss_rst_ack_n,
        input  mem_ss_cal_success,
        input  mem_ss_cal_fail
    );

    modport slave (
        input  mem_ss_rst_req_n,
        output mem_ss_rst_ack_n,
        output mem_ss_cal_success,
        output mem_ss_cal_fail
    );
endinterface

// File: rtl/mem_ss_rst_seq_sync.sv
// Two-flop synchronizer with a configurable reset level, so that a reset
// forces the synchronized value to the input's inactive level.
module mem_ss_rst_sync #(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the stable output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/mem_ss_rst_seq.sv
// Memory subsystem reset sequencer: req/ack handshake with mem_ss, then
// per-channel calibration tracking gating the AFU memory user reset.
module mem_ss_rst_seq
    import mem_ss_rst_pkg::*;
#(
    parameter int                    NUM_MEM_CH    = 4,
    parameter logic [NUM_MEM_CH-1:0] CH_MASK       = {NUM_MEM_CH{1'b1}},
    parameter int unsigned           ACK_TIMEOUT   = 65535,
    parameter int unsigned           CAL_TIMEOUT   = 1048575,
    parameter int unsigned           STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst_req,
    mem_ss_rst_seq_if.master mem_if,
    output logic [63:0]      emif_capability,
    output logic [63:0]      emif_status,
    output logic             afu_mem_rst_n,
    output logic [2:0]       seq_state
);
    localparam int unsigned TMR_MAX = max_u(ACK_TIMEOUT, CAL_TIMEOUT);
    localparam int          TMR_W   = (TMR_MAX == 32'd0) ? 1 : $clog2(TMR_MAX + 32'd1);
    localparam logic [TMR_W-1:0] TMR_SAT  = '1;
    localparam logic [TMR_W-1:0] ACK_LAST = (ACK_TIMEOUT == 32'd0) ? '0 : TMR_W'(ACK_TIMEOUT - 32'd1);
    localparam logic [TMR_W-1:0] CAL_LAST = (CAL_TIMEOUT == 32'd0) ? '0 : TMR_W'(CAL_TIMEOUT - 32'd1);
    localparam logic [7:0]       STABLE_LAST = 8'(STABLE_CYCLES - 32'd1);

    logic                  ack_n_s;
    logic [NUM_MEM_CH-1:0] succ_s;
    logic [NUM_MEM_CH-1:0] fail_s;
    logic [NUM_MEM_CH-1:0] succ_m_s;
    logic [NUM_MEM_CH-1:0] fail_m_s;
    logic                  full_s;
    logic                  ack_to_hit_s;
    logic                  cal_to_hit_s;
    logic [TMR_W-1:0]      timer_inc_s;
    logic [63:0]           sts_s;

    t_seq_state            state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [7:0]            stable_q, stable_d;
    logic [NUM_MEM_CH-1:0] done_mask_q, done_mask_d;
    logic [NUM_MEM_CH-1:0] fail_mask_q, fail_mask_d;
    logic                  ack_to_q, ack_to_d;
    logic                  cal_to_q, cal_to_d;
    logic                  cal_lost_q, cal_lost_d;
    logic                  req_n_q;
    logic                  afu_q;
    logic                  busy_q;

    mem_ss_rst_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_ack (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (mem_if.mem_ss_rst_ack_n),
        .q_o   (ack_n_s)
    );

    mem_ss_rst_sync #(.WIDTH(NUM_MEM_CH), .RST_VAL('0)) u_sync_succ (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (mem_if.mem_ss_cal_success),
        .q_o   (succ_s)
    );

    mem_ss_rst_sync #(.WIDTH(NUM_MEM_CH), .RST_VAL('0)) u_sync_fail (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (mem_if.mem_ss_cal_fail),
        .q_o   (fail_s)
    );

    assign succ_m_s     = succ_s & CH_MASK;
    assign fail_m_s     = fail_s & CH_MASK;
    assign full_s       = (succ_m_s == CH_MASK);
    assign ack_to_hit_s = (ACK_TIMEOUT != 32'd0) && (timer_q >= ACK_LAST);
    assign cal_to_hit_s = (CAL_TIMEOUT != 32'd0) && (timer_q >= CAL_LAST);
    assign timer_inc_s  = (timer_q == TMR_SAT) ? timer_q : timer_q + TMR_W'(1'b1);

    // Next-state, timer, stability counter and sticky status flags
    always_comb begin
        state_d     = state_q;
        stable_d    = stable_q;
        done_mask_d = done_mask_q;
        fail_mask_d = fail_mask_q;
        ack_to_d    = ack_to_q;
        cal_to_d    = cal_to_q;
        cal_lost_d  = cal_lost_q;
        case (state_q)
            ST_IDLE: begin
                done_mask_d = '0;
                stable_d    = 8'd0;
                state_d     = ST_REQ;
            end
            ST_REQ: begin
                if (!ack_n_s) begin
                    state_d = ST_REL;
                end else if (ack_to_hit_s) begin
                    state_d  = ST_ERR;
                    ack_to_d = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REL: begin
                if (ack_n_s) begin
                    state_d = ST_CAL;
                end else if (ack_to_hit_s) begin
                    state_d  = ST_ERR;
                    ack_to_d = 1'b1;
                end else begin
                    state_d = ST_REL;
                end
            end
            ST_CAL: begin
                done_mask_d = succ_m_s;
                if (full_s) begin
                    stable_d = (stable_q == 8'hFF) ? stable_q : stable_q + 8'd1;
                end else begin
                    stable_d = 8'd0;
                end
                // A failing channel outranks both completion and timeout
                if (|fail_m_s) begin
                    state_d     = ST_ERR;
                    fail_mask_d = fail_mask_q | fail_m_s;
                end else if (full_s && (stable_q >= STABLE_LAST)) begin
                    state_d = ST_DONE;
                end else if (cal_to_hit_s) begin
                    state_d  = ST_ERR;
                    cal_to_d = 1'b1;
                end else begin
                    state_d = ST_CAL;
                end
            end
            ST_DONE: begin
                done_mask_d = succ_m_s;
                if (sw_rst_req) begin
                    state_d     = ST_IDLE;
                    done_mask_d = '0;
                    fail_mask_d = '0;
                    ack_to_d    = 1'b0;
                    cal_to_d    = 1'b0;
                    cal_lost_d  = 1'b0;
                end else if (!full_s) begin
                    state_d    = ST_ERR;
                    cal_lost_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ERR: begin
                if (sw_rst_req) begin
                    state_d     = ST_IDLE;
                    done_mask_d = '0;
                    fail_mask_d = '0;
                    ack_to_d    = 1'b0;
                    cal_to_d    = 1'b0;
                    cal_lost_d  = 1'b0;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        timer_d = (state_d != state_q) ? '0 : timer_inc_s;
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            stable_q    <= 8'd0;
            done_mask_q <= '0;
            fail_mask_q <= '0;
            ack_to_q    <= 1'b0;
            cal_to_q    <= 1'b0;
            cal_lost_q  <= 1'b0;
            req_n_q     <= 1'b1;
            afu_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stable_q    <= stable_d;
            done_mask_q <= done_mask_d;
            fail_mask_q <= fail_mask_d;
            ack_to_q    <= ack_to_d;
            cal_to_q    <= cal_to_d;
            cal_lost_q  <= cal_lost_d;
            req_n_q     <= (state_d != ST_REQ);
            afu_q       <= (state_q == ST_DONE) && (state_d == ST_DONE);
            busy_q      <= (state_d != ST_DONE) && (state_d != ST_ERR);
        end
    end

    // Pack the status word from registered fields
    always_comb begin
        sts_s                                = 64'd0;
        sts_s[NUM_MEM_CH-1:0]                = done_mask_q;
        sts_s[STS_FAIL_LSB +: NUM_MEM_CH]    = fail_mask_q;
        sts_s[STS_BUSY]                      = busy_q;
        sts_s[STS_ACK_TO]                    = ack_to_q;
        sts_s[STS_CAL_TO]                    = cal_to_q;
        sts_s[STS_CAL_LOST]                  = cal_lost_q;
    end

    assign emif_status             = sts_s;
    assign emif_capability         = {{(64-NUM_MEM_CH){1'b0}}, CH_MASK};
    assign afu_mem_rst_n           = afu_q;
    assign seq_state               = state_q;
    assign mem_if.mem_ss_rst_req_n = req_n_q;

endmodule

// File: tb/tb_mem_ss_rst_seq.sv
// Self-checking bench for mem_ss_rst_seq: table-driven end-to-end runs with a
// scoreboard, plus hand-written multi-cycle corner cases.
module tb_mem_ss_rst_seq;
    import mem_ss_rst_pkg::*;

    typedef struct {
        int          id;
        int          ack_fall;
        int          ack_rise;
        bit          ack_never;
        logic [3:0]  succ;
        logic [3:0]  fail;
        logic [2:0]  exp_state;
        logic [63:0] exp_status;
        logic        exp_afu;
    } vec_t;

    typedef struct {
        int          id;
        logic [2:0]  state;
        logic [63:0] status;
        logic        afu;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_rst_req;
    logic [63:0] emif_capability;
    logic [63:0] emif_status;
    logic        afu_mem_rst_n;
    logic [2:0]  seq_state;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    vec_t vecs[4];

    mem_ss_rst_seq_if #(.NUM_MEM_CH(4)) mif ();

    mem_ss_rst_seq #(
        .NUM_MEM_CH    (4),
        .CH_MASK       (4'hF),
        .ACK_TIMEOUT   (50),
        .CAL_TIMEOUT   (200),
        .STABLE_CYCLES (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sw_rst_req      (sw_rst_req),
        .mem_if          (mif.master),
        .emif_capability (emif_capability),
        .emif_status     (emif_status),
        .afu_mem_rst_n   (afu_mem_rst_n),
        .seq_state       (seq_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_ok(input string name, input int n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL %s: actual=no event within bound required=event", name);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc && n < 0; i++) begin
            @(negedge clk);
            if (seq_state == st) n = i;
        end
    endtask

    task automatic wait_term(input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc && n < 0; i++) begin
            @(negedge clk);
            if (seq_state == ST_DONE || seq_state == ST_ERR) n = i;
        end
    endtask

    task automatic wait_req(input logic lvl, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc && n < 0; i++) begin
            @(negedge clk);
            if (mif.mem_ss_rst_req_n == lvl) n = i;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n                  = 1'b0;
        sw_rst_req             = 1'b0;
        mif.mem_ss_rst_ack_n   = 1'b1;
        mif.mem_ss_cal_success = 4'h0;
        mif.mem_ss_cal_fail    = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic to_cal();
        int n;
        wait_req(1'b0, 10, n);
        bound_ok("to_cal_req_low", n);
        mif.mem_ss_rst_ack_n = 1'b0;
        wait_req(1'b1, 10, n);
        bound_ok("to_cal_req_release", n);
        mif.mem_ss_rst_ack_n = 1'b1;
        wait_state(ST_CAL, 10, n);
        bound_ok("to_cal_enter_cal", n);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n;
        apply_reset();
        e.id     = v.id;
        e.state  = v.exp_state;
        e.status = v.exp_status;
        e.afu    = v.exp_afu;
        sb_q.push_back(e);
        wait_req(1'b0, 10, n);
        bound_ok($sformatf("vec%0d_req_low", v.id), n);
        if (!v.ack_never) begin
            repeat (v.ack_fall) @(negedge clk);
            mif.mem_ss_rst_ack_n = 1'b0;
            wait_req(1'b1, 20, n);
            bound_ok($sformatf("vec%0d_req_release", v.id), n);
            repeat (v.ack_rise) @(negedge clk);
            mif.mem_ss_rst_ack_n = 1'b1;
            repeat (100) @(negedge clk);
            mif.mem_ss_cal_success = v.succ;
            mif.mem_ss_cal_fail    = v.fail;
        end
        wait_term(400, n);
        bound_ok($sformatf("vec%0d_terminal", v.id), n);
        repeat (2) @(negedge clk);
        e = sb_q.pop_front();
        chk($sformatf("vec%0d_state", e.id), 64'(seq_state), 64'(e.state));
        chk($sformatf("vec%0d_status", e.id), emif_status, e.status);
        chk($sformatf("vec%0d_afu_rst_n", e.id), 64'(afu_mem_rst_n), 64'(e.afu));
        chk($sformatf("vec%0d_req_n", e.id), 64'(mif.mem_ss_rst_req_n), 64'd1);
    endtask

    initial begin
        int n;
        bit early;

        rst_n                  = 1'b0;
        sw_rst_req             = 1'b0;
        mif.mem_ss_rst_ack_n   = 1'b1;
        mif.mem_ss_cal_success = 4'h0;
        mif.mem_ss_cal_fail    = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_state", 64'(seq_state), 64'(ST_IDLE));
        chk("rst_req_n", 64'(mif.mem_ss_rst_req_n), 64'd1);
        chk("rst_afu_rst_n", 64'(afu_mem_rst_n), 64'd0);
        chk("rst_status", emif_status, 64'd0);
        chk("capability", emif_capability, 64'hF);

        vecs[0] = '{0, 10, 5, 1'b0, 4'hF, 4'h0, ST_DONE, 64'h0000_000F, 1'b1};
        vecs[1] = '{1, 10, 5, 1'b0, 4'h7, 4'h0, ST_ERR,  64'h0004_0007, 1'b0};
        vecs[2] = '{2, 3,  7, 1'b0, 4'h3, 4'h4, ST_ERR,  64'h0000_0403, 1'b0};
        vecs[3] = '{3, 0,  0, 1'b1, 4'h0, 4'h0, ST_ERR,  64'h0002_0000, 1'b0};
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Continue from the ack-timeout error: hold, soft restart, exact timeout length
        @(negedge clk);
        chk("err_holds", 64'(seq_state), 64'(ST_ERR));
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        chk("swrst_state_idle", 64'(seq_state), 64'(ST_IDLE));
        chk("swrst_status", emif_status, 64'h0001_0000);
        chk("swrst_req_n_high", 64'(mif.mem_ss_rst_req_n), 64'd1);
        @(negedge clk);
        chk("swrst_state_req", 64'(seq_state), 64'(ST_REQ));
        chk("swrst_req_n_low", 64'(mif.mem_ss_rst_req_n), 64'd0);
        wait_state(ST_ERR, 60, n);
        chk("ack_to_cycles_in_req", 64'(n), 64'd50);
        chk("ack_to_status", emif_status, 64'h0002_0000);
        chk("ack_to_req_n", 64'(mif.mem_ss_rst_req_n), 64'd1);

        // Fail pulse landing on the last timer cycle of CAL
        apply_reset();
        to_cal();
        repeat (197) @(posedge clk);
        @(negedge clk);
        mif.mem_ss_cal_fail = 4'h2;
        @(negedge clk);
        mif.mem_ss_cal_fail = 4'h0;
        @(negedge clk);
        chk("failto_still_cal", 64'(seq_state), 64'(ST_CAL));
        @(negedge clk);
        chk("failto_state", 64'(seq_state), 64'(ST_ERR));
        chk("failto_status", emif_status, 64'h0000_0200);
        repeat (5) @(negedge clk);
        chk("failto_sticky", emif_status, 64'h0000_0200);

        // sw_rst_req ignored in CAL, then a glitch restarts the stability count
        apply_reset();
        to_cal();
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        chk("swrst_ignored_cal", 64'(seq_state), 64'(ST_CAL));
        mif.mem_ss_cal_success = 4'hF;
        repeat (2) @(negedge clk);
        mif.mem_ss_cal_success = 4'hE;
        @(negedge clk);
        mif.mem_ss_cal_success = 4'hF;
        early = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (seq_state == ST_DONE) early = 1'b1;
        end
        chk("glitch_no_early_done", 64'(early), 64'd0);
        @(negedge clk);
        chk("glitch_done", 64'(seq_state), 64'(ST_DONE));
        chk("glitch_afu_lag", 64'(afu_mem_rst_n), 64'd0);
        @(negedge clk);
        chk("glitch_afu_rst_n", 64'(afu_mem_rst_n), 64'd1);
        chk("glitch_status", emif_status, 64'h0000_000F);

        // Soft reset and calibration loss seen in the same DONE cycle
        mif.mem_ss_cal_success = 4'hE;
        repeat (2) @(negedge clk);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        chk("swrst_vs_loss_state", 64'(seq_state), 64'(ST_IDLE));
        chk("swrst_vs_loss_status", emif_status, 64'h0001_0000);

        // Reset in the middle of CAL, rerun, then lose channel 0 in DONE
        apply_reset();
        to_cal();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_state", 64'(seq_state), 64'(ST_IDLE));
        chk("midrst_req_n", 64'(mif.mem_ss_rst_req_n), 64'd1);
        chk("midrst_afu_rst_n", 64'(afu_mem_rst_n), 64'd0);
        chk("midrst_status", emif_status, 64'd0);
        rst_n = 1'b1;
        to_cal();
        mif.mem_ss_cal_success = 4'hF;
        wait_state(ST_DONE, 20, n);
        bound_ok("rerun_done", n);
        @(negedge clk);
        chk("rerun_afu_rst_n", 64'(afu_mem_rst_n), 64'd1);
        mif.mem_ss_cal_success = 4'hE;
        n = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (n < 0 && afu_mem_rst_n == 1'b0) n = i;
        end
        chk("loss_afu_within_4", 64'(n >= 1 && n <= 4), 64'd1);
        chk("loss_state", 64'(seq_state), 64'(ST_ERR));
        chk("loss_status", emif_status, 64'h0008_000E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_ss_rst_seq.md
Name: mem_ss_rst_seq

Overview:
- Sequences the memory subsystem reset request/acknowledge handshake after FIM reset, then tracks per-channel EMIF calibration.
- Produces the calibration status/capability values read through the EMIF DFH feature.
- Holds the AFU-side memory user reset until every enabled channel is calibrated and stable.
- Sits between the FIM reset controller / EMIF CSR block and mem_ss_top.

Parameters:
- NUM_MEM_CH, 4, number of EMIF channels (1..8).
- CH_MASK, {NUM_MEM_CH{1'b1}}, populated-channel mask; drives emif_capability.
- ACK_TIMEOUT, 65535, max cycles waiting for rst_ack_n edge; 0 = no timeout.
- CAL_TIMEOUT, 1048575, max cycles waiting for calibration; 0 = no timeout.
- STABLE_CYCLES, 3, consecutive cycles the full mask must hold before DONE (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- sw_rst_req  in  1  single-cycle pulse from CSR; restarts the sequence from DONE or ERR.
- mem_ss_rst_req_n  out  1  reset request to mem_ss, active low.
- mem_ss_rst_ack_n  in  1  reset acknowledge from mem_ss, active low, asynchronous.
- mem_ss_cal_success  in  NUM_MEM_CH  per-channel calibration pass, asynchronous.
- mem_ss_cal_fail  in  NUM_MEM_CH  per-channel calibration fail, asynchronous.
- emif_capability  out  64  zero-extended CH_MASK, constant.
- emif_status  out  64  [NUM_MEM_CH-1:0]=cal_done_mask, [15:8]=cal_fail_mask (zero-extended), [16]=busy, [17]=ack_timeout, [18]=cal_timeout, [19]=cal_lost, others 0.
- afu_mem_rst_n  out  1  memory user reset to the AFU, active low.
- seq_state  out  3  current FSM state encoding, for debug.

Behaviour:
- Synchronization: ack_n, cal_success and cal_fail each pass through a 2-flop synchronizer. All FSM decisions use synchronized values; this adds 2 cycles of input latency.
- Reset (rst_n=0 at a clk edge), values visible the following cycle:
  - mem_ss_rst_req_n=1, afu_mem_rst_n=0, emif_status=0, state=IDLE, counters=0.
  - Synchronizer flops reset to the inactive level: ack_n=1, success=0, fail=0.
- FSM states: IDLE=0, REQ=1, REL=2, CAL=3, DONE=4, ERR=5.
- IDLE: one cycle, then REQ. busy=1 in every state except DONE and ERR.
- REQ:
  - mem_ss_rst_req_n=0 and the timer counts.
  - Synchronized ack_n==0 -> REL, timer cleared.
  - Timer reaches ACK_TIMEOUT (nonzero) -> ERR with ack_timeout=1.
- REL:
  - mem_ss_rst_req_n=1 and the timer counts.
  - Synchronized ack_n==1 -> CAL.
  - Timer reaches ACK_TIMEOUT -> ERR with ack_timeout=1.
- CAL:
  - Timer counts. cal_done_mask = sync_success & CH_MASK, updated every cycle.
  - Any sync_fail & CH_MASK bit set -> ERR; cal_fail_mask latches those bits (sticky).
  - cal_done_mask==CH_MASK increments the stable counter; any other value clears it.
  - Stable counter reaches STABLE_CYCLES -> DONE.
  - Timer reaches CAL_TIMEOUT -> ERR with cal_timeout=1.
  - If fail and timeout occur in the same cycle, fail wins: cal_fail_mask is set and cal_timeout stays 0.
- DONE:
  - afu_mem_rst_n=1, registered; asserted on the cycle after entering DONE.
  - A masked success bit dropping -> ERR with cal_lost=1; afu_mem_rst_n=0 on the next cycle.
- ERR: afu_mem_rst_n=0 and mem_ss_rst_req_n=1. Stays in ERR until sw_rst_req or rst_n.
- sw_rst_req:
  - Honoured only in DONE or ERR.
  - Clears all sticky error bits and cal_fail_mask, then goes to IDLE.
  - Ignored in IDLE, REQ, REL and CAL (no queuing).
  - If sw_rst_req and cal loss occur in the same cycle in DONE, sw_rst_req wins.
- Counters:
  - Timer width is clog2(max(ACK_TIMEOUT, CAL_TIMEOUT)+1). It saturates and never wraps.
  - Timer is cleared on every state change.
- rst_n asserted mid-sequence aborts immediately and releases req_n (1); nothing is retained.

Decomposition:
- Package mem_ss_rst_pkg holds:
  - t_seq_state enum;
  - emif_status bit-position localparams (STS_BUSY=16, STS_ACK_TO=17, STS_CAL_TO=18, STS_CAL_LOST=19, STS_FAIL_LSB=8);
  - EMIF_STATUS_OFFSET / EMIF_CAPABILITY_OFFSET shared with the CSR block.
- Sub-module mem_ss_rst_sync: parameterized-width 2-flop synchronizer with a reset value parameter, instantiated three times.

Test Plan:
- Nominal, NUM_MEM_CH=4:
  - Stimulus: ack_n falls 10 cycles after req_n falls and rises 5 cycles after release; cal_success=4'hF 100 cycles later.
  - Required: DONE STABLE_CYCLES+2 cycles after sync; emif_status=0x0F; afu_mem_rst_n=1; capability=0xF.
- Partial calibration:
  - Stimulus: cal_success=4'h7 held beyond CAL_TIMEOUT (set to 200).
  - Required: ERR; emif_status[18]=1; [3:0]=0x7; afu_mem_rst_n=0.
- Fail during CAL:
  - Stimulus: cal_fail=4'h2 pulsed for 1 cycle at the same time the timer expires.
  - Required: ERR; emif_status[15:8]=0x02 (sticky); [18]=0.
- Glitch on the mask:
  - Stimulus: success=0xF for 2 cycles, 0xE for 1 cycle, then 0xF.
  - Required: stable counter restarts; DONE only after 3 consecutive cycles of 0xF.
- Ack never arrives:
  - Stimulus: ack_n held at 1 with ACK_TIMEOUT=50.
  - Required: ERR after 50 cycles in REQ; status[17]=1; req_n=1.
  - Then a sw_rst_req pulse -> IDLE; status cleared; req_n=0 again 2 cycles later.
- Mid-operation reset and loss:
  - Stimulus: rst_n low for 1 cycle during CAL.
  - Required: all outputs return to reset values; the sequence reruns.
  - Stimulus: in DONE, success bit 0 drops.
  - Required: cal_lost=1; afu_mem_rst_n=0 within 4 cycles of the input edge.
